fp_div_seq: RTL and testbench

//  Sequential IEEE-754 single-precision divider, out = in1 / in2. Companion to the pipelined FP multiplier in the FPU.

---
 rtl/fp_div_seq_pkg.sv | 46 ++++
 rtl/fp_div_seq_divxbit.sv | 17 +
 rtl/fp_div_seq.sv | 185 ++++++++++++++++++
 tb/tb_fp_div_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_seq_pkg.sv
// Shared constants, field layout and operand classifiers for the sequential FP divider.
// Special encodings and rounding-mode codes match the pipelined FP multiplier.
package fp_div_seq_pkg;

  localparam int W  = 32;
  localparam int M  = 22;
  localparam int E  = 30;
  localparam int B  = 127;
  localparam int QB = 26;

  localparam logic [W-1:0] FP_INFP  = 32'h7F80_0000;
  localparam logic [W-1:0] FP_INFN  = 32'hFF80_0000;
  localparam logic [W-1:0] FP_ZEROP = 32'h0000_0000;
  localparam logic [W-1:0] FP_ZERON = 32'h8000_0000;
  localparam logic [W-1:0] FP_NANQ  = 32'h7FC0_0000;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RZ  = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [2:0] RU  = 3'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [1:0] S_RND   = 2'd3;

  typedef struct packed {
    logic           s;
    logic [E-M-1:0] e;
    logic [M:0]     f;
  } fp_t;

  // Denormals have a zero exponent field and are flushed, so they classify as zero.
  function automatic logic fp_is_zero(input fp_t x);
    return x.e == '0;
  endfunction

  function automatic logic fp_is_inf(input fp_t x);
    return (&x.e) && (x.f == '0);
  endfunction

  function automatic logic fp_is_nan(input fp_t x);
    return (&x.e) && (|x.f);
  endfunction

endpackage

// File: rtl/fp_div_seq_divxbit.sv
// One restoring-division step: emit a quotient bit and the shifted partial remainder.
// Purely combinational; remainder stays below 2*den so 25 bits suffice.
module divxbit (
  input  logic [24:0] rem,
  input  logic [23:0] den,
  output logic        qbit,
  output logic [24:0] rem_next
);

  logic [23:0] diff;

  // When rem >= den the true difference is below den, so the low 24 bits are exact.
  assign qbit     = rem >= {1'b0, den};
  assign diff     = rem[23:0] - den;
  assign rem_next = qbit ? {diff, 1'b0} : {rem[23:0], 1'b0};

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider, one quotient bit per clock.
// Special operands finish 1 clock after act; normal operands 28 clocks after act.
module fp_div_seq
  import fp_div_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         done,
  output logic         busy,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact,
  output logic         dz
);

  logic [1:0]        state;
  fp_t               a, b;
  logic [2:0]        rm;
  logic [24:0]       rem;
  logic [23:0]       den;
  logic [QB-1:0]     q;
  logic signed [9:0] exp_r;
  logic              sgn;
  logic [4:0]        cnt;

  logic              qbit;
  logic [24:0]       rem_next;

  divxbit u_step (
    .rem      (rem),
    .den      (den),
    .qbit     (qbit),
    .rem_next (rem_next)
  );

  logic         s_c, spec_hit, spec_inv, spec_dz;
  logic [W-1:0] spec_out;

  assign s_c = a.s ^ b.s;

  always_comb begin
    spec_hit = 1'b1;
    spec_out = FP_NANQ;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    if (fp_is_nan(a) || fp_is_nan(b) || (fp_is_inf(a) && fp_is_inf(b)) ||
        (fp_is_zero(a) && fp_is_zero(b))) begin
      spec_inv = 1'b1;
    end else if (fp_is_zero(b) || fp_is_inf(a)) begin
      spec_out = s_c ? FP_INFN : FP_INFP;
      spec_dz  = fp_is_zero(b) && !fp_is_inf(a);
    end else if (fp_is_zero(a) || fp_is_inf(b)) begin
      spec_out = s_c ? FP_ZERON : FP_ZEROP;
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [QB-1:0]     qn;
  logic signed [9:0] en, er;
  logic [23:0]       sig;
  logic              g, t, inc;
  logic [24:0]       sum;
  logic [22:0]       frac;
  logic [W-1:0]      rnd_out;
  logic              rnd_ov, rnd_un, rnd_inx;

  always_comb begin
    if (q[QB-1]) begin
      qn = q;
      en = exp_r;
    end else begin
      qn = {q[QB-2:0], 1'b0};
      en = exp_r - 10'sd1;
    end
    sig = qn[25:2];
    g   = qn[1];
    t   = qn[0] | (|rem);
    case (rm)
      RNE:     inc = g & (t | sig[0]);
      RZ:      inc = 1'b0;
      RD:      inc = sgn & (g | t);
      RU:      inc = !sgn & (g | t);
      default: inc = g;
    endcase
    sum     = {1'b0, sig} + {24'd0, inc};
    er      = en + (sum[24] ? 10'sd1 : 10'sd0);
    frac    = sum[24] ? sum[23:1] : sum[22:0];
    rnd_ov  = 1'b0;
    rnd_un  = 1'b0;
    rnd_inx = g | t;
    rnd_out = {sgn, er[7:0], frac};
    if (er > 10'sd254) begin
      rnd_out = sgn ? FP_INFN : FP_INFP;
      rnd_ov  = 1'b1;
      rnd_inx = 1'b1;
    end else if (er < 10'sd1) begin
      rnd_out = sgn ? FP_ZERON : FP_ZEROP;
      rnd_un  = 1'b1;
      rnd_inx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      a       <= '0;
      b       <= '0;
      rm      <= '0;
      rem     <= '0;
      den     <= '0;
      q       <= '0;
      exp_r   <= '0;
      sgn     <= 1'b0;
      cnt     <= '0;
      out     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ov      <= 1'b0;
      un      <= 1'b0;
      inv     <= 1'b0;
      inexact <= 1'b0;
      dz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (act) begin
            a     <= in1;
            b     <= in2;
            rm    <= round_m;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (spec_hit) begin
            out     <= spec_out;
            inv     <= spec_inv;
            dz      <= spec_dz;
            ov      <= 1'b0;
            un      <= 1'b0;
            inexact <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            rem   <= {2'b01, a.f};
            den   <= {1'b1, b.f};
            exp_r <= $signed({2'b00, a.e}) - $signed({2'b00, b.e}) + $signed(10'(B));
            sgn   <= s_c;
            q     <= '0;
            cnt   <= 5'(QB - 1);
            state <= S_DIV;
          end
        end
        S_DIV: begin
          q   <= {q[QB-2:0], qbit};
          rem <= rem_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= S_RND;
        end
        S_RND: begin
          out     <= rnd_out;
          ov      <= rnd_ov;
          un      <= rnd_un;
          inexact <= rnd_inx;
          inv     <= 1'b0;
          dz      <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed cases, reset abort, back-to-back and random operands.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        act = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [2:0]  round_m = '0;
  logic [31:0] out;
  logic        done, busy, ov, un, inv, inexact, dz;

  typedef struct packed {
    logic [31:0] out;
    logic [4:0]  flg;   // {ov, un, inv, inexact, dz}
  } res_t;

  typedef struct {
    res_t res;
    int   lat;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t mon_e;
  res_t mon_got;

  fp_div_seq dut (
    .clk     (clk),
    .rst     (rst),
    .act     (act),
    .in1     (in1),
    .in2     (in2),
    .round_m (round_m),
    .out     (out),
    .done    (done),
    .busy    (busy),
    .ov      (ov),
    .un      (un),
    .inv     (inv),
    .inexact (inexact),
    .dz      (dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer quotient of the significands, then IEEE rounding rules.
  function automatic res_t ref_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    res_t        r;
    logic        s, g, t, inc;
    int          ex, ey, e;
    longint      m1, m2, n, quo, rmd, sig;
    logic [31:0] inf_v, zero_v;
    logic [7:0]  e8;
    r      = '0;
    s      = x[31] ^ y[31];
    ex     = int'(x[30:23]);
    ey     = int'(y[30:23]);
    inf_v  = {s, 8'hFF, 23'd0};
    zero_v = {s, 31'd0};
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
        (ex == 255 && ey == 255) || (ex == 0 && ey == 0)) begin
      r.out = 32'h7FC0_0000;
      r.flg = 5'b00100;
      return r;
    end
    if (ey == 0) begin
      r.out = inf_v;
      r.flg = (ex == 255) ? 5'b00000 : 5'b00001;
      return r;
    end
    if (ex == 255) begin
      r.out = inf_v;
      return r;
    end
    if (ex == 0 || ey == 255) begin
      r.out = zero_v;
      return r;
    end
    m1  = longint'({1'b1, x[22:0]});
    m2  = longint'({1'b1, y[22:0]});
    e   = ex - ey + 127;
    n   = m1 <<< 25;
    quo = n / m2;
    if (quo < (64'sd1 <<< 25)) begin
      n   = m1 <<< 26;
      quo = n / m2;
      e   = e - 1;
    end
    rmd = n % m2;
    sig = quo >>> 2;
    g   = quo[1];
    t   = quo[0] || (rmd != 0);
    case (rm)
      3'd0:    inc = g && (t || sig[0]);
      3'd1:    inc = 1'b0;
      3'd2:    inc = s && (g || t);
      3'd3:    inc = !s && (g || t);
      default: inc = g;
    endcase
    sig = sig + longint'(inc);
    if (sig == (64'sd1 <<< 24)) begin
      sig = sig >>> 1;
      e   = e + 1;
    end
    r.flg[1] = g || t;
    if (e > 254) begin
      r.out = inf_v;
      r.flg = 5'b10010;
    end else if (e < 1) begin
      r.out = zero_v;
      r.flg = 5'b01010;
    end else begin
      e8    = e[7:0];
      r.out = {s, e8, sig[22:0]};
    end
    return r;
  endfunction

  function automatic int lat_of(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00 || x[30:23] == 8'hFF || y[30:23] == 8'h00 || y[30:23] == 8'hFF) ? 1 : 28;
  endfunction

  function automatic logic [31:0] rand_fp(input bit normal_only);
    int          k;
    logic [7:0]  ex;
    logic [22:0] fr;
    logic        s;
    k  = normal_only ? 19 : $urandom_range(0, 19);
    fr = 23'($urandom);
    s  = 1'($urandom);
    if (k == 0) ex = 8'h00;
    else if (k == 1) begin ex = 8'hFF; fr = '0; end
    else if (k == 2) begin ex = 8'hFF; fr[0] = 1'b1; end
    else if (k < 6) ex = 8'($urandom_range(1, 254));
    else begin
      ex = 8'($urandom_range(110, 144));
      if (k == 7) fr = {fr[22:18], 18'd0};
    end
    return {s, ex, fr};
  endfunction

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                      input res_t r, input bit hold, input bit push);
    exp_t e;
    in1     = x;
    in2     = y;
    round_m = m;
    act     = 1'b1;
    @(posedge clk);
    #1;
    e.res = r;
    e.lat = lat_of(x, y);
    e.cyc = cyc;
    if (push) exp_q.push_back(e);
    if (!hold) act = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within 60 cycles, required one");
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation, value and latency.
  always @(negedge clk) begin
    if (rst && done) begin
      mon_got = {out, ov, un, inv, inexact, dz};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with out=%h, required none", out);
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if (mon_got !== mon_e.res) begin
          bad++;
          $display("FAIL result: got out=%h flags=%b, required out=%h flags=%b",
                   mon_got.out, mon_got.flg, mon_e.res.out, mon_e.res.flg);
        end
        total++;
        if (cyc - mon_e.cyc != mon_e.lat) begin
          bad++;
          $display("FAIL latency: got %0d, required %0d", cyc - mon_e.cyc, mon_e.lat);
        end
      end
    end
  end

  logic [31:0] t_a   [7] = '{32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                             32'h0000_0000, 32'h7F00_0000, 32'h0080_0000};
  logic [31:0] t_b   [7] = '{32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 32'h0000_0000,
                             32'h0000_0000, 32'h0080_0000, 32'h4000_0000};
  logic [2:0]  t_m   [7] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [31:0] t_out [7] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'h3EAA_AAAA, 32'h7F80_0000,
                             32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000};
  logic [4:0]  t_flg [7] = '{5'b00000, 5'b00010, 5'b00010, 5'b00001,
                             5'b00100, 5'b10010, 5'b01010};

  initial begin
    int          dc, prev, ndone;
    logic [31:0] x, y;
    logic [2:0]  m;

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({out, done, busy, ov, un, inv, inexact, dz} !== '0) begin
      bad++;
      $display("FAIL reset_state: got out=%h done=%b busy=%b flags=%b%b%b%b%b, required all 0",
               out, done, busy, ov, un, inv, inexact, dz);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send(t_a[i], t_b[i], t_m[i], {t_out[i], t_flg[i]}, 1'b0, 1'b1);
      wait_done(dc);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Abort a normal division at its tenth DIV cycle.
    send(32'h40C0_0000, 32'h4000_0000, 3'd0, '0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({out, done, busy, ov, un, inv, inexact, dz} !== '0) begin
      bad++;
      $display("FAIL reset_abort: got out=%h done=%b busy=%b flags=%b%b%b%b%b, required all 0",
               out, done, busy, ov, un, inv, inexact, dz);
    end
    @(negedge clk);
    rst   = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", ndone);
    end

    send(t_a[1], t_b[1], t_m[1], {t_out[1], t_flg[1]}, 1'b0, 1'b1);
    wait_done(dc);
    @(negedge clk);

    // act held high: each op is sampled in the previous op's done cycle.
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      x = rand_fp(1'b1);
      y = rand_fp(1'b1);
      m = 3'($urandom_range(0, 7));
      send(x, y, m, ref_div(x, y, m), 1'b1, 1'b1);
      wait_done(dc);
      if (prev >= 0 && dc >= 0) begin
        total++;
        if (dc - prev != 29) begin
          bad++;
          $display("FAIL b2b_period: got %0d cycles between dones, required 29", dc - prev);
        end
      end
      prev = dc;
    end
    act = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 50; i++) begin
      x = rand_fp(1'b0);
      y = rand_fp(1'b0);
      m = 3'($urandom_range(0, 7));
      send(x, y, m, ref_div(x, y, m), 1'b0, 1'b1);
      wait_done(dc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d outstanding results, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
